// File: rtl/gshare_fetch_predictor.sv
// rtl/gshare_fetch_predictor.sv - multi-lane gshare next-fetch-PC predictor with tagged BTB
// One-cycle lookup from the latched fetch PC; tables are swept clear after every reset.
module gshare_fetch_predictor #(
   parameter int FETCH_W   = 2,
   parameter int IDX_BITS  = 10,
   parameter int HIST_BITS = 8,
   parameter int TAG_BITS  = 20,
   localparam int LW = (FETCH_W > 1) ? $clog2(FETCH_W) : 1
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   input  logic                 pc_we_i,
   input  logic [31:0]          pc_i,
   input  logic                 update_i,
   input  logic [31:0]          update_pc_i,
   input  logic [31:0]          update_tgt_i,
   input  logic                 update_taken_i,
   input  logic                 update_is_br_i,
   input  logic [HIST_BITS-1:0] update_ghr_i,
   input  logic                 mispredict_i,
   output logic                 busy_o,
   output logic [FETCH_W-1:0]   hit_o,
   output logic [FETCH_W-1:0]   taken_o,
   output logic                 pred_taken_o,
   output logic [LW-1:0]        pred_lane_o,
   output logic [31:0]          pred_next_pc_o,
   output logic [HIST_BITS-1:0] ghr_o
);

   localparam int ENTRIES = 1 << IDX_BITS;
   localparam int TAG_LSB = IDX_BITS + 2;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [IDX_BITS-1:0]  clr_idx_q, clr_idx_d;
   logic [HIST_BITS-1:0] ghr_q, ghr_d;
   logic [31:0]          pc_q, pc_d;

   logic                 btb_valid_q [ENTRIES];
   logic [TAG_BITS-1:0]  btb_tag_q   [ENTRIES];
   logic [31:2]          btb_tgt_q   [ENTRIES];
   logic [1:0]           pht_q       [ENTRIES];

   logic                 run;
   logic [FETCH_W-1:0]   hit, taken;
   logic [31:0]          lane_tgt [FETCH_W];
   logic [LW-1:0]        pred_lane;
   logic [31:0]          pred_next;
   logic                 pred_taken;

   function automatic logic [HIST_BITS-1:0] shift_in(input logic [HIST_BITS-1:0] h,
                                                     input logic b);
      logic [HIST_BITS:0] t;
      t = {h, b};
      return t[HIST_BITS-1:0];
   endfunction

   assign run = (state_q == ST_RUN);

   for (genvar k = 0; k < FETCH_W; k++) begin : g_lane
      logic [31:0]         lpc;
      logic [IDX_BITS-1:0] bidx, pidx;
      logic                unused_lane;
      assign lpc         = pc_q + 32'(4 * k);
      assign bidx        = lpc[IDX_BITS+1:2];
      assign pidx        = bidx ^ IDX_BITS'(ghr_q);
      assign hit[k]      = run && btb_valid_q[bidx] && (btb_tag_q[bidx] == lpc[TAG_LSB +: TAG_BITS]);
      assign taken[k]    = hit[k] && pht_q[pidx][1];
      assign lane_tgt[k] = {btb_tgt_q[bidx], 2'b00};
      assign unused_lane = ^lpc[1:0];
   end

   // Descending scan so the lowest taken lane is the one that sticks.
   always_comb begin
      pred_lane = '0;
      pred_next = pc_q + 32'(4 * FETCH_W);
      for (int k = FETCH_W - 1; k >= 0; k--) begin
         if (taken[k]) begin
            pred_lane = LW'(k);
            pred_next = lane_tgt[k];
         end
      end
   end

   assign pred_taken = |taken;

   logic [IDX_BITS-1:0] upd_bidx, upd_pidx;
   logic [1:0]          upd_ctr, upd_ctr_next;
   logic                upd_en;
   logic                unused_upd;

   assign upd_bidx   = update_pc_i[IDX_BITS+1:2];
   assign upd_pidx   = upd_bidx ^ IDX_BITS'(update_ghr_i);
   assign upd_ctr    = pht_q[upd_pidx];
   assign upd_en     = run && update_i && !reset_i;
   assign unused_upd = ^{update_pc_i[1:0], update_tgt_i[1:0]};

   always_comb begin
      upd_ctr_next = upd_ctr;
      if (update_taken_i) begin
         if (upd_ctr != 2'b11) upd_ctr_next = upd_ctr + 2'b01;
      end else begin
         if (upd_ctr != 2'b00) upd_ctr_next = upd_ctr - 2'b01;
      end
   end

   always_ff @(posedge clock_i) begin
      if (!reset_i && state_q == ST_INIT) begin
         btb_valid_q[clr_idx_q] <= 1'b0;
         pht_q[clr_idx_q]       <= 2'b01;
      end else if (upd_en) begin
         if (update_is_br_i) begin
            pht_q[upd_pidx] <= upd_ctr_next;
            if (update_taken_i) begin
               btb_valid_q[upd_bidx] <= 1'b1;
               btb_tag_q[upd_bidx]   <= update_pc_i[TAG_LSB +: TAG_BITS];
               btb_tgt_q[upd_bidx]   <= update_tgt_i[31:2];
            end
         end else begin
            btb_valid_q[upd_bidx] <= 1'b0;
         end
      end
   end

   // Restore from the resolved instruction outranks the speculative shift.
   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      ghr_d     = ghr_q;
      pc_d      = pc_q;
      case (state_q)
         ST_INIT: begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (&clr_idx_q) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (update_i && mispredict_i)
               ghr_d = update_is_br_i ? shift_in(update_ghr_i, update_taken_i) : update_ghr_i;
            else if (pc_we_i && !mispredict_i && (|hit))
               ghr_d = shift_in(ghr_q, pred_taken);
            if (pc_we_i) pc_d = pc_i;
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q   <= ST_INIT;
         clr_idx_q <= '0;
         ghr_q     <= '0;
         pc_q      <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         ghr_q     <= ghr_d;
         pc_q      <= pc_d;
      end
   end

   assign busy_o         = (state_q == ST_INIT);
   assign hit_o          = hit;
   assign taken_o        = taken;
   assign pred_taken_o   = pred_taken;
   assign pred_lane_o    = pred_lane;
   assign pred_next_pc_o = pred_next;
   assign ghr_o          = ghr_q;

endmodule
